mmio_key_sw_device: RTL

Memory-mapped input responder for the single-cycle processor's data-memory port. It answers processor loads and stores at the KEY and SW addresses, and at two new control/status addresses. Raw board KEY[3:0] and SW[9:0] pass through a two-flop synchronizer and per-bit debounce. Key presses and switch changes are captured into sticky ready/overrun status bits that software polls and clears.

---
 rtl/mmio_key_sw_device_pkg.sv | 43 ++++
 rtl/mmio_key_sw_device_debouncer.sv | 76 +++++++
 rtl/mmio_key_sw_device.sv | 109 ++++++++++
 3 files changed

// File: rtl/mmio_key_sw_device_pkg.sv
// Shared MMIO address map, CTRL bit layout and status update rule for the board I/O responders.
// Pure declarations: no latency, no flow control.
package mmio_pkg;

    localparam logic [31:0] ADDR_HEX   = 32'hF0000000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF0000004;
    localparam logic [31:0] ADDR_LEDG  = 32'hF0000008;
    localparam logic [31:0] ADDR_KDATA = 32'hF0000010;
    localparam logic [31:0] ADDR_SDATA = 32'hF0000014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF0000110;
    localparam logic [31:0] ADDR_SCTRL = 32'hF0000114;

    localparam int READY_BIT   = 0;
    localparam int OVERRUN_BIT = 2;
    localparam int KEY_BITS    = 4;
    localparam int SW_BITS     = 10;

    typedef struct packed {
        logic overrun;
        logic ready;
    } status_t;

    // An event always wins over a clear in the same cycle and then leaves overrun alone.
    function automatic status_t status_next(status_t cur, logic evt, logic clr_rdy, logic clr_ovr);
        status_t nxt;
        nxt = cur;
        if (evt) begin
            if (cur.ready && !clr_rdy && !clr_ovr) begin
                nxt.overrun = 1'b1;
            end
            nxt.ready = 1'b1;
        end else begin
            if (clr_rdy) begin
                nxt.ready = 1'b0;
            end
            if (clr_ovr) begin
                nxt.overrun = 1'b0;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mmio_key_sw_device_debouncer.sv
// Two-flop synchronizer plus per-bit debounce counters (counters only with MMIO_DEBOUNCE_EN).
// Latency E+1+DEBOUNCE_CYCLES (E+2 without counters); no backpressure.
module input_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] change
);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [WIDTH-1:0] stable_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt      [WIDTH];
    logic [CW-1:0] cnt_next [WIDTH];

    // Count cycles of disagreement; any agreement restarts the run.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i]    = '0;
            stable_next[i] = stable[i];
            if (sync_q2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_next[i] = sync_q2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (!reset) begin
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt_next[i];
            end
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign stable_next = sync_q2;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            stable <= '0;
        end else begin
            stable <= stable_next;
        end
    end

    // Bits that flip at the coming edge, so status can rise on the same edge as stable.
    assign change = stable_next ^ stable;

endmodule

// File: rtl/mmio_key_sw_device.sv
// KEY/SW memory-mapped responder with sticky ready/overrun status; debounce depth set by MMIO_DEBOUNCE_EN.
// Reads are combinational (zero latency), status updates on the edge ending the access; no backpressure.
module mmio_key_sw_device
    import mmio_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_KDATA      = mmio_pkg::ADDR_KDATA,
    parameter logic [DBITS-1:0] ADDR_SDATA      = mmio_pkg::ADDR_SDATA,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = mmio_pkg::ADDR_KCTRL,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = mmio_pkg::ADDR_SCTRL,
    parameter int               DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wr_data,
    output logic [DBITS-1:0] rd_data,
    output logic             rd_hit,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW
);

    logic [KEY_BITS-1:0] key_stable;
    logic [KEY_BITS-1:0] key_change;
    logic [SW_BITS-1:0]  sw_stable;
    logic [SW_BITS-1:0]  sw_change;
    logic [KEY_BITS-1:0] key_raw;

    status_t key_status;
    status_t sw_status;

    logic key_event;
    logic sw_event;
    logic key_clr_rdy;
    logic key_clr_ovr;
    logic sw_clr_rdy;
    logic sw_clr_ovr;

    // Board keys are active-low; present pressed as 1.
    assign key_raw = ~KEY;

    input_debouncer #(
        .WIDTH           (KEY_BITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (key_raw),
        .stable (key_stable),
        .change (key_change)
    );

    input_debouncer #(
        .WIDTH           (SW_BITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (SW),
        .stable (sw_stable),
        .change (sw_change)
    );

    assign key_event = |(key_change & ~key_stable);
    assign sw_event  = |sw_change;

    assign key_clr_rdy = (rd_en && addr == ADDR_KDATA) ||
                         (wr_en && addr == ADDR_KCTRL && !wr_data[READY_BIT]);
    assign key_clr_ovr = wr_en && addr == ADDR_KCTRL && !wr_data[OVERRUN_BIT];
    assign sw_clr_rdy  = (rd_en && addr == ADDR_SDATA) ||
                         (wr_en && addr == ADDR_SCTRL && !wr_data[READY_BIT]);
    assign sw_clr_ovr  = wr_en && addr == ADDR_SCTRL && !wr_data[OVERRUN_BIT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_status <= '0;
            sw_status  <= '0;
        end else begin
            key_status <= status_next(key_status, key_event, key_clr_rdy, key_clr_ovr);
            sw_status  <= status_next(sw_status, sw_event, sw_clr_rdy, sw_clr_ovr);
        end
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        if (addr == ADDR_KDATA) begin
            rd_hit                  = 1'b1;
            rd_data[KEY_BITS-1:0]   = key_stable;
        end else if (addr == ADDR_SDATA) begin
            rd_hit                  = 1'b1;
            rd_data[SW_BITS-1:0]    = sw_stable;
        end else if (addr == ADDR_KCTRL) begin
            rd_hit                  = 1'b1;
            rd_data[READY_BIT]      = key_status.ready;
            rd_data[OVERRUN_BIT]    = key_status.overrun;
        end else if (addr == ADDR_SCTRL) begin
            rd_hit                  = 1'b1;
            rd_data[READY_BIT]      = sw_status.ready;
            rd_data[OVERRUN_BIT]    = sw_status.overrun;
        end
        if (!reset) begin
            rd_data = '0;
        end
    end

endmodule
